seg_scan_arbiter: RTL and testbench
===================================

Name: seg_scan_arbiter

Overview:
Scan controller and display arbiter for the 4-digit 7-segment debug display of the multi-cycle CPU board.
- Time-multiplexes the four digits, with a programmable blanking gap at the start of every digit slot to avoid ghosting.
- Arbitrates the display between the switch-selected CPU debug pages and a one-shot message requester.
- Drives digit nibble and anode lines; the downstream segment decoder turns the nibble into segment code.

Parameters:
TICK_DIV, 50000, CLK cycles per digit slot (>= 2).
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off (0 < BLANK_CYC < TICK_DIV).
HOLD_FRAMES, 64, full scan frames a granted message stays on screen (>= 1).

Ports:
CLK  in  1  system clock
Reset  in  1  synchronous, active-low reset
page_sel  in  2  switch-selected debug page
page_data  in  64  four 16-bit pages; page n at [16n+15:16n]; digit k of a page shows bits [4k+3:4k]
msg_req  in  1  message request level, held until acked
msg_data  in  16  message word, sampled on ack
msg_ack  out  1  one-cycle pulse: message accepted and latched
msg_active  out  1  message currently owns the display
cur_page  out  2  page index currently latched for display
an  out  4  active-low digit enables, digit 0 = an[0]
digit_val  out  4  nibble for the currently enabled digit

Behaviour:
- Reset (Reset==0 at a CLK edge) clears everything: prescaler=0, digit=0, shown_word=0, state=PAGE, hold count=0. Outputs: an=4'b1111, digit_val=0, msg_ack=0, msg_active=0, cur_page=0. Reset mid-message abandons it; no ack is issued.
- Prescaler counts 0..TICK_DIV-1 and wraps. slot_end = (prescaler==TICK_DIV-1).
- Digit index advances at slot_end: 0->1->2->3->0.
- frame_end = slot_end && digit==3.
- an, digit_val, msg_active and cur_page decode combinationally from registers; no extra latency.
- an = 4'b1111 while prescaler < BLANK_CYC. Otherwise an = ~(1<<digit).
- digit_val = shown_word[4*digit+3 : 4*digit] at all times, including the blank window.
- shown_word, cur_page and msg_active change only at frame_end, so there is no mid-frame tearing. page_sel and page_data changes mid-frame take effect at the next frame_end.
- FSM state PAGE:
  - At frame_end with msg_req==1: load shown_word=msg_data, pulse msg_ack in that same cycle, hold=HOLD_FRAMES-1, go to MSG.
  - At frame_end otherwise: load shown_word=page_data[page_sel], cur_page=page_sel.
- FSM state MSG (msg_active=1):
  - At frame_end with hold!=0: hold decrements.
  - At frame_end with hold==0: load page_data[page_sel], go to PAGE.
- Fairness: msg_req is not accepted at the frame_end that exits MSG. The page is guaranteed at least one full frame before the next message.
- msg_req in MSG is ignored (no ack). msg_req dropped before the ack is never acked.
- msg_ack is high for exactly one cycle per accepted message.

Decomposition:
- Shared display package holds:
  - state encoding (PAGE=1'b0, MSG=1'b1);
  - AN_OFF=4'b1111;
  - page index constants: PG_PC=0, PG_RS=1, PG_RT=2, PG_ALU=3.
- One natural sub-module: seg_scan_timer. It contains the prescaler, digit counter and slot_end/frame_end/blank generation, parameterised by TICK_DIV and BLANK_CYC. Arbitration and word latch stay in the top.

Test Plan:
(All scenarios use TICK_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2; frame = 32 cycles.)
1. Reset: hold Reset=0 for 5 cycles -> an=1111, digit_val=0, msg_ack=0. After release: slot cycles 0-1 an=1111, cycles 2-7 an=1110.
2. page_sel=2, page 2 = 16'hA5C3 -> after first frame_end: digits 0..3 show 3,C,5,A with an 1110,1101,1011,0111 (each after 2 blank cycles); cur_page=2.
3. Switch page_sel 2->1 at mid-frame cycle 10 -> display unchanged until frame_end; then page 1 shown, cur_page=1.
4. msg_req=1, msg_data=16'hBEEF, held -> msg_ack one-cycle pulse at next frame_end. F,E,E,B shown for 2 frames with msg_active=1. Then page shown one frame, then re-acked.
5. Reset=0 during the second message frame -> all outputs at reset values next cycle, no ack; after release, PAGE behaviour resumes.
6. Run 3 frames free -> exactly 12 slots, digit order 0,1,2,3 repeating, no missing or double slot at the prescaler/digit wrap.

Source files
------------

// File: rtl/seg_scan_arbiter_pkg.sv
// Shared definitions for the 7-segment debug display scan/arbitration slice.
package seg_scan_arbiter_pkg;

    typedef enum logic {
        PAGE = 1'b0,
        MSG  = 1'b1
    } disp_state_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [1:0] PG_PC  = 2'd0;
    localparam logic [1:0] PG_RS  = 2'd1;
    localparam logic [1:0] PG_RT  = 2'd2;
    localparam logic [1:0] PG_ALU = 2'd3;

endpackage

// File: rtl/seg_scan_arbiter_if.sv
// Display-side bundle: page/message sources in, anode/nibble and status out.
interface seg_scan_arbiter_if;

    logic [1:0]  page_sel;
    logic [63:0] page_data;
    logic        msg_req;
    logic [15:0] msg_data;
    logic        msg_ack;
    logic        msg_active;
    logic [1:0]  cur_page;
    logic [3:0]  an;
    logic [3:0]  digit_val;

    modport master (
        output page_sel, page_data, msg_req, msg_data,
        input  msg_ack, msg_active, cur_page, an, digit_val
    );

    modport slave (
        input  page_sel, page_data, msg_req, msg_data,
        output msg_ack, msg_active, cur_page, an, digit_val
    );

endinterface

// File: rtl/seg_scan_arbiter_timer.sv
// Digit-slot timebase: prescaler, digit index, and slot/frame/blank strobes.
module seg_scan_timer #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       CLK,
    input  logic       Reset,
    output logic [1:0] digit,
    output logic       slot_end,
    output logic       frame_end,
    output logic       blank
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [1:0]    digit_q;

    assign slot_end  = (presc_q == PW'(TICK_DIV - 1));
    assign frame_end = slot_end && (digit_q == 2'd3);
    assign blank     = (presc_q < PW'(BLANK_CYC));
    assign digit     = digit_q;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            presc_q <= '0;
            digit_q <= 2'd0;
        end else if (slot_end) begin
            presc_q <= '0;
            digit_q <= digit_q + 2'd1;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_arbiter.sv
// Scans the 4-digit display and arbitrates it between debug pages and one-shot messages.
module seg_scan_arbiter
    import seg_scan_arbiter_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int BLANK_CYC   = 1000,
    parameter int HOLD_FRAMES = 64
) (
    input  logic               CLK,
    input  logic               Reset,
    seg_scan_arbiter_if.slave  bus
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    logic [1:0]  digit;
    logic        slot_end;
    logic        frame_end;
    logic        blank;

    disp_state_t state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0] shown_q, shown_d;
    logic [1:0]  page_q, page_d;
    logic        ack;
    logic [15:0] page_word;

    seg_scan_timer #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .CLK       (CLK),
        .Reset     (Reset),
        .digit     (digit),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .blank     (blank)
    );

    assign page_word = bus.page_data[16*bus.page_sel +: 16];

    // Everything visible only moves at frame_end so a frame is never torn.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        shown_d = shown_q;
        page_d  = page_q;
        ack     = 1'b0;
        if (frame_end) begin
            case (state_q)
                PAGE: begin
                    if (bus.msg_req) begin
                        shown_d = bus.msg_data;
                        hold_d  = HW'(HOLD_FRAMES - 1);
                        state_d = MSG;
                        ack     = 1'b1;
                    end else begin
                        shown_d = page_word;
                        page_d  = bus.page_sel;
                    end
                end
                MSG: begin
                    // Exit ignores msg_req, so a page always gets a full frame.
                    if (hold_q != '0) begin
                        hold_d = hold_q - HW'(1);
                    end else begin
                        shown_d = page_word;
                        page_d  = bus.page_sel;
                        state_d = PAGE;
                    end
                end
                default: state_d = PAGE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= PAGE;
            hold_q  <= '0;
            shown_q <= 16'h0000;
            page_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            shown_q <= shown_d;
            page_q  <= page_d;
        end
    end

    assign bus.msg_ack    = ack && Reset;
    assign bus.msg_active = (state_q == MSG);
    assign bus.cur_page   = page_q;
    assign bus.an         = blank ? AN_OFF : ~(4'b0001 << digit);
    assign bus.digit_val  = shown_q[4*digit +: 4];

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter with TICK_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2.
module tb_seg_scan_arbiter;

    logic CLK;
    logic Reset;
    int   total;
    int   bad;
    int   cyc;

    seg_scan_arbiter_if bus ();

    seg_scan_arbiter #(
        .TICK_DIV    (8),
        .BLANK_CYC   (2),
        .HOLD_FRAMES (2)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) step(1);
    endtask

    function automatic logic [3:0] an_of(input logic [1:0] d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    logic [3:0] pg2 [4];
    logic [3:0] prev_an;
    logic [1:0] exp_d;
    int         slots;
    int         active;
    int         acks;

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        pg2   = '{4'h3, 4'hC, 4'h5, 4'hA};
        Reset = 1'b0;
        bus.page_sel  = 2'd2;
        bus.page_data = {16'hD00D, 16'hA5C3, 16'h7E81, 16'h1234};
        bus.msg_req   = 1'b0;
        bus.msg_data  = 16'h0000;

        // Reset
        repeat (5) @(negedge CLK);
        chk("rst_an",     bus.an, 4'b1111);
        chk("rst_dval",   bus.digit_val, 4'h0);
        chk("rst_ack",    bus.msg_ack, 1'b0);
        chk("rst_active", bus.msg_active, 1'b0);
        chk("rst_page",   bus.cur_page, 2'd0);

        Reset = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_an", bus.an, (i < 2) ? 4'b1111 : 4'b1110);
            step(1);
        end
        goto(31);
        chk("t1_page_f0", bus.cur_page, 2'd0);
        chk("t1_dval_f0", bus.digit_val, 4'h0);

        // Page 2 shown, switch to page 1 mid-frame
        for (int k = 0; k < 4; k++) begin
            goto(32 + 8*k);
            chk("t2_an_blank", bus.an, 4'b1111);
            chk("t2_dval_blank", bus.digit_val, pg2[k]);
            step(2);
            chk("t2_an", bus.an, an_of(k[1:0]));
            chk("t2_dval", bus.digit_val, pg2[k]);
            chk("t2_page", bus.cur_page, 2'd2);
            if (k == 1) bus.page_sel = 2'd1;
        end
        goto(63);
        chk("t3_page_hold", bus.cur_page, 2'd2);
        chk("t3_dval_hold", bus.digit_val, 4'hA);
        goto(64);
        chk("t3_page_new", bus.cur_page, 2'd1);
        chk("t3_dval_d0", bus.digit_val, 4'h1);
        goto(74);
        chk("t3_an_d1", bus.an, 4'b1101);
        chk("t3_dval_d1", bus.digit_val, 4'h8);

        // Message request held
        bus.msg_req  = 1'b1;
        bus.msg_data = 16'hBEEF;
        goto(94);
        chk("t4_ack_early", bus.msg_ack, 1'b0);
        goto(95);
        chk("t4_ack", bus.msg_ack, 1'b1);
        chk("t4_active_pre", bus.msg_active, 1'b0);
        goto(96);
        chk("t4_ack_once", bus.msg_ack, 1'b0);
        chk("t4_active", bus.msg_active, 1'b1);
        chk("t4_d0", bus.digit_val, 4'hF);
        chk("t4_page_kept", bus.cur_page, 2'd1);
        goto(106);
        chk("t4_d1", bus.digit_val, 4'hE);
        goto(114);
        chk("t4_d2", bus.digit_val, 4'hE);
        goto(122);
        chk("t4_d3", bus.digit_val, 4'hB);
        chk("t4_an_d3", bus.an, 4'b0111);
        goto(127);
        chk("t4_ack_inmsg", bus.msg_ack, 1'b0);
        goto(128);
        chk("t4_active_f2", bus.msg_active, 1'b1);
        chk("t4_d0_f2", bus.digit_val, 4'hF);
        goto(159);
        chk("t4_ack_fair", bus.msg_ack, 1'b0);
        goto(160);
        chk("t4_active_off", bus.msg_active, 1'b0);
        chk("t4_page_back", bus.digit_val, 4'h1);
        chk("t4_curpage", bus.cur_page, 2'd1);
        goto(191);
        chk("t4_reack", bus.msg_ack, 1'b1);
        goto(192);
        chk("t4_active2", bus.msg_active, 1'b1);
        chk("t4_ack2_once", bus.msg_ack, 1'b0);

        // Reset during the second frame of the second message
        goto(230);
        Reset = 1'b0;
        step(1);
        chk("t5_an", bus.an, 4'b1111);
        chk("t5_dval", bus.digit_val, 4'h0);
        chk("t5_ack", bus.msg_ack, 1'b0);
        chk("t5_active", bus.msg_active, 1'b0);
        chk("t5_page", bus.cur_page, 2'd0);
        step(2);
        chk("t5_ack_hold", bus.msg_ack, 1'b0);
        bus.msg_req = 1'b0;
        Reset = 1'b1;
        cyc = 0;
        goto(31);
        chk("t5_ack_after", bus.msg_ack, 1'b0);
        chk("t5_active_after", bus.msg_active, 1'b0);
        goto(32);
        chk("t5_page_after", bus.cur_page, 2'd1);
        chk("t5_dval_after", bus.digit_val, 4'h1);

        // Three free-running frames
        prev_an = bus.an;
        exp_d   = 2'd0;
        slots   = 0;
        active  = 0;
        acks    = 0;
        for (int i = 0; i < 96; i++) begin
            step(1);
            if (bus.msg_ack) acks++;
            if (bus.an != 4'b1111) active++;
            if (bus.an != 4'b1111 && prev_an == 4'b1111) begin
                chk("t6_order", bus.an, an_of(exp_d));
                slots++;
                exp_d = exp_d + 2'd1;
            end
            prev_an = bus.an;
        end
        chk("t6_slots", slots, 12);
        chk("t6_active", active, 72);
        chk("t6_acks", acks, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
